// File: rtl/multicycle_ctrl_if.sv
// multicycle_ctrl_if: instruction/data memory handshakes and datapath control bundle for the sequencer
interface multicycle_ctrl_if #(
  parameter int n     = 16,
  parameter int CNT_W = 32
);
  logic [n-1:0]     instr;
  logic             zero;
  logic             imem_req;
  logic             imem_ack;
  logic             dmem_req;
  logic             dmem_we;
  logic             dmem_ack;
  logic             ir_en;
  logic             mdr_en;
  logic             pcen;
  logic             regwrite;
  logic             memtoreg;
  logic             alusrc;
  logic             regdst;
  logic             jump;
  logic             pcsrc;
  logic [3:0]       alucontrol;
  logic             halted;
  logic             illegal;
  logic [CNT_W-1:0] cyc_count;
  logic [CNT_W-1:0] ret_count;
  modport master (
    input  instr, zero, imem_ack, dmem_ack,
    output imem_req, dmem_req, dmem_we, ir_en, mdr_en, pcen, regwrite, memtoreg,
           alusrc, regdst, jump, pcsrc, alucontrol, halted, illegal, cyc_count, ret_count
  );
  modport slave (
    output instr, zero, imem_ack, dmem_ack,
    input  imem_req, dmem_req, dmem_we, ir_en, mdr_en, pcen, regwrite, memtoreg,
           alusrc, regdst, jump, pcsrc, alucontrol, halted, illegal, cyc_count, ret_count
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: fetch/decode/execute/memory/writeback sequencer for the 16-bit datapath; MC_PERF_CNT_EN adds cycle/retire counters
module multicycle_ctrl #(
  parameter int n     = 16,
  parameter int CNT_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  multicycle_ctrl_if.master bus
);
  typedef enum logic [2:0] {
    S_RST, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
  } state_t;
  state_t     state_q, state_d;
  logic [6:0] ir_q, ir_d;
  logic       illegal_q, illegal_d;
  logic [3:0] op;
  logic [2:0] fn;
  logic       is_r, is_addi, is_lw, is_sw, is_beq, is_jr, is_halt, op_ok, fn_ok, sel;
  logic [3:0] r_alu;
  assign op      = ir_q[6:3];
  assign fn      = ir_q[2:0];
  assign is_r    = op == 4'h0;
  assign is_addi = op == 4'h1;
  assign is_lw   = op == 4'h2;
  assign is_sw   = op == 4'h3;
  assign is_beq  = op == 4'h4;
  assign is_jr   = op == 4'h5;
  assign is_halt = op == 4'hF;
  assign op_ok   = is_r | is_addi | is_lw | is_sw | is_beq | is_jr | is_halt;
  assign fn_ok   = fn <= 3'd4;
  assign r_alu   = fn == 3'd1 ? 4'b0110 :
                   fn == 3'd2 ? 4'b0000 :
                   fn == 3'd3 ? 4'b0001 :
                   fn == 3'd4 ? 4'b0111 : 4'b0010;
  // only opcode and funct are needed after fetch, so the IR keeps just those bits
  assign ir_d    = bus.ir_en ? bus.instr[n-1 -: 7] : ir_q;
  // state, instruction register and sticky illegal flag
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_RST;
      ir_q      <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ir_q      <= ir_d;
      illegal_q <= illegal_d;
    end
  end
  // next state and per-state strobes; acks only matter in the state that issues the request
  always_comb begin
    state_d      = state_q;
    illegal_d    = illegal_q;
    bus.imem_req = 1'b0;
    bus.dmem_req = 1'b0;
    bus.dmem_we  = 1'b0;
    bus.ir_en    = 1'b0;
    bus.mdr_en   = 1'b0;
    bus.pcen     = 1'b0;
    bus.regwrite = 1'b0;
    bus.memtoreg = 1'b0;
    bus.jump     = 1'b0;
    bus.pcsrc    = 1'b0;
    bus.halted   = 1'b0;
    case (state_q)
      S_RST:    state_d = S_FETCH;
      S_FETCH: begin
        bus.imem_req = 1'b1;
        bus.ir_en    = bus.imem_ack;
        state_d      = bus.imem_ack ? S_DECODE : S_FETCH;
      end
      S_DECODE: state_d = S_EXEC;
      S_EXEC: begin
        illegal_d = illegal_q | ~op_ok | (is_r & ~fn_ok);
        bus.pcsrc = is_beq & bus.zero;
        bus.jump  = is_jr;
        bus.pcen  = ~(is_r | is_addi | is_lw | is_sw | is_halt);
        state_d   = (is_r | is_addi) ? S_WB :
                    (is_lw | is_sw)  ? S_MEM :
                    is_halt          ? S_HALT : S_FETCH;
      end
      S_MEM: begin
        bus.dmem_req = 1'b1;
        bus.dmem_we  = is_sw;
        bus.pcen     = bus.dmem_ack & is_sw;
        bus.mdr_en   = bus.dmem_ack & is_lw;
        state_d      = !bus.dmem_ack ? S_MEM : is_sw ? S_FETCH : S_WB;
      end
      S_WB: begin
        bus.regwrite = 1'b1;
        bus.pcen     = 1'b1;
        bus.memtoreg = is_lw;
        state_d      = S_FETCH;
      end
      S_HALT:   bus.halted = 1'b1;
      default:  state_d = S_RST;
    endcase
  end
  assign sel            = state_q == S_EXEC || state_q == S_MEM || state_q == S_WB;
  assign bus.regdst     = sel & is_r;
  assign bus.alusrc     = sel & (is_addi | is_lw | is_sw);
  assign bus.alucontrol = !sel ? 4'b0000 : is_beq ? 4'b0110 : !is_r ? 4'b0010 : r_alu;
  assign bus.illegal    = illegal_q;
`ifdef MC_PERF_CNT_EN
  logic [CNT_W-1:0] cyc_q, cyc_d, ret_q, ret_d;
  assign cyc_d = cyc_q + CNT_W'(state_q != S_RST && state_q != S_HALT);
  assign ret_d = ret_q + CNT_W'(bus.pcen);
  // free-running performance counters, wrapping naturally
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cyc_q <= '0;
      ret_q <= '0;
    end else begin
      cyc_q <= cyc_d;
      ret_q <= ret_d;
    end
  end
  assign bus.cyc_count = cyc_q;
  assign bus.ret_count = ret_q;
`else
  assign bus.cyc_count = {CNT_W{1'b0}};
  assign bus.ret_count = {CNT_W{1'b0}};
`endif
endmodule
